// File: rtl/discus_pkg.sv
// discus_pkg: opcode field values, FSM state encoding and snoop register
// indices shared by the discus accumulator CPU and its ALU.
package discus_pkg;

  // Major opcode (instruction bits [7:4])
  localparam logic [3:0] OP_CTL = 4'h0;  // NOP / jumps / LDI
  localparam logic [3:0] OP_MOV = 4'h4;
  localparam logic [3:0] OP_ADD = 4'h5;
  localparam logic [3:0] OP_SUB = 4'h6;
  localparam logic [3:0] OP_LOG = 4'h7;  // AND / OR
  localparam logic [3:0] OP_XOR = 4'h8;  // XOR / CMP
  localparam logic [3:0] OP_MEM = 4'h9;  // LD / ST
  localparam logic [3:0] OP_SHF = 4'hA;  // shifts / HALT
  localparam logic [3:0] OP_IDC = 4'hC;  // DEC / INC Rr
  localparam logic [3:0] OP_UNR = 4'hD;  // CLR / NOT Rr
  localparam logic [3:0] OP_ACC = 4'hE;  // CLR / INC A

  // Full-byte control opcodes
  localparam logic [7:0] IR_NOP = 8'h00;
  localparam logic [7:0] IR_JMP = 8'h01;
  localparam logic [7:0] IR_JZ  = 8'h02;
  localparam logic [7:0] IR_JNZ = 8'h03;
  localparam logic [7:0] IR_JC  = 8'h04;
  localparam logic [7:0] IR_JNC = 8'h05;

  // FSM states
  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_IMM  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  // Snoop register-space indices (0-7 are R0-R7)
  localparam logic [3:0] SN_A     = 4'd8;
  localparam logic [3:0] SN_PC    = 4'd9;
  localparam logic [3:0] SN_FLAGS = 4'd10;

  // Jumps and LDI carry an immediate byte
  function automatic logic is_two_byte(input logic [7:0] ir);
    return ((ir >= IR_JMP) && (ir <= IR_JNC)) || (ir[7:3] == 5'b00001);
  endfunction

endpackage

// File: rtl/discus_alu.sv
// discus_alu: combinational datapath for arithmetic, logic, shift and
// increment/decrement ops. r_i selects the shift variant for op A.
module discus_alu
  import discus_pkg::*;
(
  input  logic [7:0] a_i,
  input  logic [7:0] operand_i,
  input  logic [3:0] op_i,
  input  logic       v_i,
  input  logic [2:0] r_i,
  input  logic       cin_i,
  output logic [7:0] result_o,
  output logic       cout_o,
  output logic       z_o
);

  logic [8:0] sum9;

  // Result/carry per op; carry passes through unchanged for ops that do not own it
  always_comb begin
    sum9     = '0;
    result_o = a_i;
    cout_o   = cin_i;
    case (op_i)
      OP_ADD: begin
        sum9     = {1'b0, a_i} + {1'b0, operand_i} + {8'd0, v_i & cin_i};
        result_o = sum9[7:0];
        cout_o   = sum9[8];
      end
      OP_SUB: begin
        sum9     = {1'b0, a_i} - {1'b0, operand_i} - {8'd0, v_i & cin_i};
        result_o = sum9[7:0];
        cout_o   = sum9[8];
      end
      OP_LOG: result_o = v_i ? (a_i | operand_i) : (a_i & operand_i);
      OP_XOR: begin
        if (v_i) begin
          sum9     = {1'b0, a_i} - {1'b0, operand_i};
          result_o = sum9[7:0];
          cout_o   = sum9[8];
        end else begin
          result_o = a_i ^ operand_i;
        end
      end
      OP_SHF: begin
        case (r_i[1:0])
          2'd0:    {cout_o, result_o} = {a_i, 1'b0};
          2'd1:    {result_o, cout_o} = {1'b0, a_i};
          2'd2:    {cout_o, result_o} = {a_i, cin_i};
          default: {result_o, cout_o} = {cin_i, a_i};
        endcase
      end
      OP_IDC: begin
        if (v_i) begin
          result_o = operand_i + 8'd1;
          cout_o   = (operand_i == 8'hFF);
        end else begin
          result_o = operand_i - 8'd1;
          cout_o   = (operand_i == 8'h00);
        end
      end
      OP_UNR: result_o = v_i ? ~operand_i : 8'h00;
      OP_ACC: begin
        if (v_i) begin
          result_o = a_i + 8'd1;
          cout_o   = (a_i == 8'hFF);
        end else begin
          result_o = 8'h00;
        end
      end
      default: ;
    endcase
  end

  assign z_o = (result_o == 8'h00);

endmodule

// File: rtl/discus.sv
// discus: 8-bit accumulator CPU with 256x8 unified memory and a debug
// snoop port. Snoop readback (snoopq) is built only when DISCUS_SNOOP_READ_EN
// is defined; otherwise snoopq is tied to zero.
module discus
  import discus_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       snoop_clk,
  input  logic [7:0] snoopa,
  input  logic [7:0] snoopd,
  output logic [7:0] snoopq,
  input  logic       snoopm,
  input  logic       snoopp
);

  logic [7:0] mem_q [256];
  logic [7:0] regs_q [8];
  logic [7:0] regs_d [8];
  logic [7:0] pc_q, pc_d, a_q, a_d, ir_q, ir_d;
  logic       z_q, z_d, c_q, c_d;
  state_e     state_q, state_d;

  logic [7:0] fetch, rsel, ld_data;
  logic [3:0] op_f;
  logic       v_f;
  logic [2:0] r_f;
  logic       st_en;
  logic [7:0] alu_res;
  logic       alu_c, alu_z;

  // snoop_clk exists only for interface compatibility
  logic unused_snoop_clk;
  assign unused_snoop_clk = snoop_clk;

  assign fetch   = mem_q[pc_q];
  assign op_f    = fetch[7:4];
  assign v_f     = fetch[3];
  assign r_f     = fetch[2:0];
  assign rsel    = regs_q[r_f];
  assign ld_data = mem_q[rsel];

  discus_alu u_alu (
    .a_i       (a_q),
    .operand_i (rsel),
    .op_i      (op_f),
    .v_i       (v_f),
    .r_i       (r_f),
    .cin_i     (c_q),
    .result_o  (alu_res),
    .cout_o    (alu_c),
    .z_o       (alu_z)
  );

  // Next-state: snoop writes while paused, otherwise fetch/execute
  always_comb begin
    pc_d    = pc_q;
    a_d     = a_q;
    regs_d  = regs_q;
    z_d     = z_q;
    c_d     = c_q;
    ir_d    = ir_q;
    state_d = state_q;
    st_en   = 1'b0;
    if (snoopp) begin
      if (snoopm) begin
        case (snoopa[3:0])
          SN_A:     a_d = snoopd;
          SN_PC: begin
            pc_d    = snoopd;
            state_d = ST_RUN;
          end
          SN_FLAGS: {c_d, z_d} = snoopd[1:0];
          default:  if (!snoopa[3]) regs_d[snoopa[2:0]] = snoopd;
        endcase
      end
    end else begin
      case (state_q)
        ST_RUN: begin
          pc_d = pc_q + 8'd1;
          case (op_f)
            OP_CTL: begin
              if (is_two_byte(fetch)) begin
                ir_d    = fetch;
                state_d = ST_IMM;
              end
            end
            OP_MOV: begin
              if (!v_f) begin
                a_d = rsel;
                z_d = (rsel == 8'h00);
              end else begin
                regs_d[r_f] = a_q;
                z_d         = (a_q == 8'h00);
              end
            end
            OP_ADD, OP_SUB, OP_LOG, OP_ACC: begin
              a_d = alu_res;
              z_d = alu_z;
              c_d = alu_c;
            end
            OP_XOR: begin
              if (!v_f) a_d = alu_res;
              z_d = alu_z;
              c_d = alu_c;
            end
            OP_MEM: begin
              if (!v_f) begin
                a_d = ld_data;
                z_d = (ld_data == 8'h00);
              end else begin
                st_en = 1'b1;
              end
            end
            OP_SHF: begin
              if (v_f) begin
                pc_d    = pc_q;
                state_d = ST_HALT;
              end else if (!r_f[2]) begin
                a_d = alu_res;
                z_d = alu_z;
                c_d = alu_c;
              end
            end
            OP_IDC, OP_UNR: begin
              regs_d[r_f] = alu_res;
              z_d         = alu_z;
              c_d         = alu_c;
            end
            default: ;
          endcase
        end
        ST_IMM: begin
          pc_d    = pc_q + 8'd1;
          state_d = ST_RUN;
          case (ir_q)
            IR_JMP:  pc_d = fetch;
            IR_JZ:   if (z_q)  pc_d = fetch;
            IR_JNZ:  if (!z_q) pc_d = fetch;
            IR_JC:   if (c_q)  pc_d = fetch;
            IR_JNC:  if (!c_q) pc_d = fetch;
            default: if (ir_q[7:3] == 5'b00001) regs_d[ir_q[2:0]] = fetch;
          endcase
        end
        default: ;
      endcase
    end
  end

  // CPU architectural state with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= '0;
      a_q     <= '0;
      ir_q    <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      state_q <= ST_RUN;
      for (int unsigned i = 0; i < 8; i++) regs_q[i] <= '0;
    end else begin
      pc_q    <= pc_d;
      a_q     <= a_d;
      ir_q    <= ir_d;
      z_q     <= z_d;
      c_q     <= c_d;
      state_q <= state_d;
      regs_q  <= regs_d;
    end
  end

  // Memory write port: snoop writes also work under reset; CPU stores are gated by it
  always_ff @(posedge clk) begin
    if (snoopp && !snoopm) begin
      mem_q[snoopa] <= snoopd;
    end else if (st_en && !reset) begin
      mem_q[rsel] <= a_q;
    end
  end

`ifdef DISCUS_SNOOP_READ_EN
  logic [7:0] snoop_rd;
  logic [7:0] snoopq_q;

  // Readback mux over memory or register space
  always_comb begin
    snoop_rd = '0;
    if (!snoopm) begin
      snoop_rd = mem_q[snoopa];
    end else begin
      case (snoopa[3:0])
        SN_A:     snoop_rd = a_q;
        SN_PC:    snoop_rd = pc_q;
        SN_FLAGS: snoop_rd = {6'd0, c_q, z_q};
        default:  if (!snoopa[3]) snoop_rd = regs_q[snoopa[2:0]];
      endcase
    end
  end

  // One-cycle registered readback, independent of snoopp
  always_ff @(posedge clk or posedge reset) begin
    if (reset) snoopq_q <= '0;
    else       snoopq_q <= snoop_rd;
  end

  assign snoopq = snoopq_q;
`else
  assign snoopq = '0;
`endif

endmodule

// File: tb/tb_discus.sv
// tb_discus: directed-vector bench for the discus CPU.
module tb_discus;
  import discus_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] snoopa, snoopd, snoopq;
  logic       snoopm, snoopp;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [7:0]  prog [$];

  always #5 clk = ~clk;

  discus dut (
    .clk       (clk),
    .reset     (reset),
    .snoop_clk (clk),
    .snoopa    (snoopa),
    .snoopd    (snoopd),
    .snoopq    (snoopq),
    .snoopm    (snoopm),
    .snoopp    (snoopp)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Load prog[] at address 0 while held in reset with the snoop port
  task automatic load_prog();
    @(negedge clk);
    reset  = 1'b1;
    snoopp = 1'b1;
    snoopm = 1'b0;
    foreach (prog[i]) begin
      snoopa = 8'(i);
      snoopd = prog[i];
      @(negedge clk);
    end
  endtask

  task automatic run(input int unsigned n);
    reset  = 1'b0;
    snoopp = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_t1(input string pfx);
    check({pfx, "_state"}, 16'(dut.state_q), 16'(ST_HALT));
    check({pfx, "_pc"},    16'(dut.pc_q),    16'h0B);
    check({pfx, "_a"},     16'(dut.a_q),     16'h11);
    check({pfx, "_r1"},    16'(dut.regs_q[1]), 16'h03);
    check({pfx, "_r2"},    16'(dut.regs_q[2]), 16'hFF);
    check({pfx, "_r3"},    16'(dut.regs_q[3]), 16'h10);
    check({pfx, "_z"},     16'(dut.z_q),     16'h0);
    check({pfx, "_c"},     16'(dut.c_q),     16'h0);
  endtask

  function automatic logic [7:0] rb(input logic [7:0] v);
`ifdef DISCUS_SNOOP_READ_EN
    return v;
`else
    return 8'h00 & v;
`endif
  endfunction

  initial begin
    reset = 1'b1; snoopp = 1'b1; snoopm = 1'b1; snoopa = 8'h0F; snoopd = 8'h00;
    @(negedge clk);
    check("rst_pc",    16'(dut.pc_q), 16'h00);
    check("rst_a",     16'(dut.a_q),  16'h00);
    check("rst_state", 16'(dut.state_q), 16'(ST_RUN));
    check("rst_snoopq", 16'(snoopq), 16'h00);

    // Test 1: main program
    prog = '{8'h50, 8'he8, 8'h91, 8'hda, 8'h0b, 8'h10, 8'h43, 8'he8, 8'hc9, 8'hc9, 8'hc9, 8'ha8};
    load_prog();
    check("t1_rst_r1", 16'(dut.regs_q[1]), 16'h00);
    check("t1_mem4",   16'(dut.mem_q[4]),  16'h0B);
    run(21);
    check_t1("t1");

    // Test 2: snoop readback and register-space writes
    snoopp = 1'b1; snoopm = 1'b1; snoopa = 8'h01; snoopd = 8'h3C;
    @(negedge clk);
    check("t2_rb_r1_old", 16'(snoopq), 16'(rb(8'h03)));
    check("t2_wr_r1",     16'(dut.regs_q[1]), 16'h3C);
    check("t2_pc_held",   16'(dut.pc_q), 16'h0B);
    @(negedge clk);
    check("t2_rb_r1_new", 16'(snoopq), 16'(rb(8'h3C)));
    snoopa = 8'h08; snoopd = 8'h11;
    @(negedge clk);
    check("t2_rb_a", 16'(snoopq), 16'(rb(8'h11)));
    snoopm = 1'b0; snoopa = 8'h04; snoopd = 8'h0B;
    @(negedge clk);
    check("t2_rb_mem4", 16'(snoopq), 16'(rb(8'h0B)));
    snoopm = 1'b1; snoopa = 8'h0A; snoopd = 8'h03;
    @(negedge clk);
    check("t2_flag_c", 16'(dut.c_q), 16'h1);
    check("t2_flag_z", 16'(dut.z_q), 16'h1);
    snoopa = 8'h09; snoopd = 8'h20;
    @(negedge clk);
    check("t2_pc_wr",   16'(dut.pc_q), 16'h20);
    check("t2_unhalt",  16'(dut.state_q), 16'(ST_RUN));
    check("t2_rb_flags", 16'(snoopq), 16'(rb(8'h03)));

    // Test 3: INC wraps
    prog = '{8'h08, 8'hff, 8'hc8, 8'ha8};
    load_prog();
    run(10);
    check("t3_r0",    16'(dut.regs_q[0]), 16'h00);
    check("t3_z",     16'(dut.z_q), 16'h1);
    check("t3_c",     16'(dut.c_q), 16'h1);
    check("t3_pc",    16'(dut.pc_q), 16'h03);
    check("t3_state", 16'(dut.state_q), 16'(ST_HALT));

    // Test 4: DEC loop with JNZ
    prog = '{8'h08, 8'h02, 8'hc0, 8'h03, 8'h02, 8'ha8};
    load_prog();
    run(20);
    check("t4_r0",    16'(dut.regs_q[0]), 16'h00);
    check("t4_pc",    16'(dut.pc_q), 16'h05);
    check("t4_z",     16'(dut.z_q), 16'h1);
    check("t4_c",     16'(dut.c_q), 16'h0);
    check("t4_state", 16'(dut.state_q), 16'(ST_HALT));

    // Test 5: asynchronous reset mid-run
    prog = '{8'h50, 8'he8, 8'h91, 8'hda, 8'h0b, 8'h10, 8'h43, 8'he8, 8'hc9, 8'hc9, 8'hc9, 8'ha8};
    load_prog();
    run(5);
    check("t5_pre_pc",    16'(dut.pc_q), 16'h05);
    check("t5_pre_a",     16'(dut.a_q), 16'h50);
    check("t5_pre_state", 16'(dut.state_q), 16'(ST_IMM));
    #2 reset = 1'b1;
    #1;
    check("t5_async_pc",    16'(dut.pc_q), 16'h00);
    check("t5_async_a",     16'(dut.a_q), 16'h00);
    check("t5_async_r2",    16'(dut.regs_q[2]), 16'h00);
    check("t5_async_state", 16'(dut.state_q), 16'(ST_RUN));
    @(negedge clk);
    check("t5_mem0", 16'(dut.mem_q[0]), 16'h50);
    run(21);
    check_t1("t5");

    // Test 6: pause mid-run holds all state
    reset = 1'b1;
    @(negedge clk);
    run(6);
    snoopp = 1'b1; snoopm = 1'b1; snoopa = 8'h0F; snoopd = 8'hAA;
    repeat (5) @(negedge clk);
    check("t6_hold_pc",    16'(dut.pc_q), 16'h06);
    check("t6_hold_a",     16'(dut.a_q), 16'h50);
    check("t6_hold_r3",    16'(dut.regs_q[3]), 16'h10);
    check("t6_hold_state", 16'(dut.state_q), 16'(ST_RUN));
    run(21);
    check_t1("t6");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
